// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio-path sample width, I2S slot size and stereo pair type
package audio_pkg;

  localparam int AUDIO_WIDTH   = 24;
  localparam int I2S_SLOT_BITS = 32;

  typedef struct packed {
    logic [AUDIO_WIDTH-1:0] left;
    logic [AUDIO_WIDTH-1:0] right;
  } stereo_t;

endpackage

// File: rtl/audio_reg.sv
// rtl/audio_reg.sv - load-enable register with synchronous clear to zero
module audio_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/i2s_bclk_gen.sv
// rtl/i2s_bclk_gen.sv - BCLK divider; fall_o strobes in the clk whose edge drives bclk low
module i2s_bclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic bclk_o,
  output logic fall_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  logic          tick;

  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    bclk_d    = tick ? ~bclk_q : bclk_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign bclk_o = bclk_q;
  assign fall_o = tick & bclk_q;

endmodule

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S master transmitter, one stereo pair per frame; I2S_TX_HOLD_LAST_EN repeats the last pair on underrun
module i2s_tx
  import audio_pkg::*;
#(
  parameter int WIDTH     = AUDIO_WIDTH,
  parameter int SLOT_BITS = I2S_SLOT_BITS,
  parameter int CLK_DIV   = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] sample_l_i,
  input  logic [WIDTH-1:0] sample_r_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             bclk_o,
  output logic             lrclk_o,
  output logic             sdata_o,
  output logic             underrun_o
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int IW = $clog2(FRAME_BITS);
  localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_BITS - 1);

  logic                 fall;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic                 buf_full_q, buf_full_d;
  logic                 in_ready_q;
  logic                 lrclk_q, lrclk_d;
  logic                 sdata_q, sdata_d;
  logic                 underrun_q, underrun_d;
  logic                 xfer, frame_load, frame_en;
  logic [2*WIDTH-1:0]   buf_q, frame_q, frame_d;
  logic [WIDTH-1:0]     word, mask;

  i2s_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bclk_o (bclk_o),
    .fall_o (fall)
  );

  assign xfer = in_valid_i & in_ready_q;

  audio_reg #(.W(2*WIDTH)) u_hold (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   (xfer),
    .d_i    ({sample_l_i, sample_r_i}),
    .q_o    (buf_q)
  );

  audio_reg #(.W(2*WIDTH)) u_frame (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   (frame_en),
    .d_i    (frame_d),
    .q_o    (frame_q)
  );

  always_comb begin : next_state
    int nxt;
    int pos;
    nxt  = (int'(bit_idx_q) == FRAME_BITS - 1) ? 0 : int'(bit_idx_q) + 1;
    pos  = (nxt >= SLOT_BITS) ? nxt - SLOT_BITS : nxt;
    word = (nxt >= SLOT_BITS) ? frame_q[WIDTH-1:0] : frame_q[2*WIDTH-1:WIDTH];
    // pos=1 carries the MSB (one-BCLK I2S delay); pos=0 shifts the bit out of range
    mask = WIDTH'(1) << (WIDTH - pos);

    frame_load = fall && (nxt == 0);
    bit_idx_d  = fall ? IW'(nxt) : bit_idx_q;
    lrclk_d    = fall ? (((nxt + 1) % FRAME_BITS) >= SLOT_BITS) : lrclk_q;
    sdata_d    = sdata_q;
    if (fall) begin
      sdata_d = (pos >= 1 && pos <= WIDTH) ? |(word & mask) : 1'b0;
    end

    underrun_d = frame_load & ~buf_full_q;
    buf_full_d = xfer ? 1'b1 : (frame_load ? 1'b0 : buf_full_q);
    frame_d    = buf_full_q ? buf_q : '0;
`ifdef I2S_TX_HOLD_LAST_EN
    frame_en   = frame_load & buf_full_q;
`else
    frame_en   = frame_load;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bit_idx_q  <= IDX_LAST;
      buf_full_q <= 1'b0;
      in_ready_q <= 1'b0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      bit_idx_q  <= bit_idx_d;
      buf_full_q <= buf_full_d;
      in_ready_q <= ~buf_full_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
    end
  end

  assign in_ready_o = in_ready_q;
  assign lrclk_o    = lrclk_q;
  assign sdata_o    = sdata_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - scoreboard bench for i2s_tx: frames expected in play order, monitor decodes the serial stream
module tb_i2s_tx;
  import audio_pkg::*;

  localparam int W = AUDIO_WIDTH;
`ifdef I2S_TX_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  typedef struct {
    stereo_t s;
    bit      und;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] sample_l = '0;
  logic [W-1:0] sample_r = '0;
  logic         in_ready_o, bclk_o, lrclk_o, sdata_o, underrun_o;

  always #5 clk = ~clk;

  i2s_tx #(.WIDTH(W), .SLOT_BITS(32), .CLK_DIV(2)) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .sample_l_i(sample_l),
    .sample_r_i(sample_r),
    .in_valid_i(in_valid),
    .in_ready_o(in_ready_o),
    .bclk_o    (bclk_o),
    .lrclk_o   (lrclk_o),
    .sdata_o   (sdata_o),
    .underrun_o(underrun_o)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  int          extra_und = 0;
  int          tb_idx = 63;
  exp_t        exp_q[$];
  stereo_t     last_s = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_pair(input stereo_t s);
    exp_t e;
    e.s = s;
    e.und = 1'b0;
    exp_q.push_back(e);
    last_s = s;
  endtask

  task automatic push_und();
    exp_t e;
    e.s = HOLD ? last_s : '0;
    e.und = 1'b1;
    exp_q.push_back(e);
    last_s = e.s;
  endtask

  task automatic send(input logic [W-1:0] l, input logic [W-1:0] r, input bit keep, input bit play);
    int n = 0;
    stereo_t s;
    sample_l = l;
    sample_r = r;
    in_valid = 1'b1;
    while (in_ready_o !== 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_ready_seen", 64'(in_ready_o), 64'd1);
    @(posedge clk); #1;
    if (!keep) in_valid = 1'b0;
    chk("ready_low_after_xfer", 64'(in_ready_o), 64'd0);
    if (play) begin
      s.left = l;
      s.right = r;
      push_pair(s);
    end
  endtask

  task automatic wait_idx(input int k);
    int n = 0;
    while (tb_idx == k && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    while (tb_idx != k && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_idx", 64'(tb_idx == k), 64'd1);
  endtask

  logic [5:0]  mon_idx = 6'd63;
  logic [63:0] sd_v = '0;
  logic [63:0] lr_v = '0;
  bit          started = 1'b0;
  bit          prev_bclk = 1'b0;
  bit          und_seen = 1'b0;
  int          cnt = 0;

  task automatic check_frame();
    exp_t        e;
    logic [63:0] v;
    if (exp_q.size() == 0) begin
      chk("frame_expected", 64'(exp_q.size()), 64'd1);
      return;
    end
    e = exp_q.pop_front();
    v = '0;
    for (int j = 0; j < 24; j++) begin
      v[6'(1 + j)]  = e.s.left[5'(23 - j)];
      v[6'(33 + j)] = e.s.right[5'(23 - j)];
    end
    chk("frame_sdata", sd_v, v);
    chk("frame_lrclk", lr_v, 64'h7FFF_FFFF_8000_0000);
    chk("frame_underrun", 64'(und_seen), 64'(e.und));
    chk("frame_period", 64'(cnt), 64'd254);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      mon_idx = 6'd63;
      started = 1'b0;
      prev_bclk = 1'b0;
      cnt = 0;
    end else begin
      cnt++;
      if (prev_bclk && !bclk_o) begin
        mon_idx = mon_idx + 6'd1;
        if (mon_idx == 6'd0) begin
          started = 1'b1;
          cnt = 0;
          und_seen = underrun_o;
          sd_v = '0;
          lr_v = '0;
        end else if (underrun_o) begin
          extra_und++;
        end
      end else if (underrun_o) begin
        extra_und++;
      end
      if (!prev_bclk && bclk_o) begin
        sd_v[mon_idx] = sdata_o;
        lr_v[mon_idx] = lrclk_o;
        if (mon_idx == 6'd63 && started) check_frame();
      end
      prev_bclk = bclk_o;
    end
    tb_idx = int'(mon_idx);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    stereo_t s;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({bclk_o, lrclk_o, sdata_o, underrun_o, in_ready_o}), 64'd0);
    push_und();
    reset = 1'b0;

    wait_idx(5);
    send(24'h800001, 24'h7FFFFE, 1'b0, 1'b1);
    wait_idx(0);
    chk("ready_after_load", 64'(in_ready_o), 64'd1);

    for (int i = 1; i <= 3; i++) begin
      send(24'(32'h100000 + i), 24'(32'hF00000 + i), 1'b1, 1'b1);
    end
    send(24'h123456, 24'h123456, 1'b0, 1'b1);
    push_und();
    wait_idx(0);
    wait_idx(0);
    wait_idx(63);

    push_und();
    n = 0;
    while (bclk_o !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    sample_l = 24'hA5A5A5;
    sample_r = 24'h5A5A5A;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("same_clk_underrun", 64'(underrun_o), 64'd1);
    chk("same_clk_ready_low", 64'(in_ready_o), 64'd0);
    s.left = 24'hA5A5A5;
    s.right = 24'h5A5A5A;
    push_pair(s);

    wait_idx(0);
    wait_idx(0);
    send(24'hDEAD01, 24'hBEEF02, 1'b0, 1'b0);
    wait_idx(42);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_abort", 64'({bclk_o, lrclk_o, sdata_o, in_ready_o}), 64'd0);
    exp_q.delete();
    last_s = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    send(24'h0F0F0F, 24'hC3C3C3, 1'b0, 1'b1);
    push_und();

    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("stray_underrun", 64'(extra_und), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
